// File: rtl/shared_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_memory_arbiter
// Purpose  : Round-robin arbiter sharing one single-port memory among
//            PROC_CNT processors; one access in flight at a time.
// Revision : 1.0  initial release
// ============================================================================
module shared_memory_arbiter #(
    parameter int PROC_CNT = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [PROC_CNT-1:0]        proc_req,
    input  logic [PROC_CNT-1:0]        proc_we,
    input  logic [PROC_CNT*ADDR_W-1:0] proc_addr,
    input  logic [PROC_CNT*DATA_W-1:0] proc_wdata,
    output logic [PROC_CNT-1:0]        proc_ack,
    output logic [DATA_W-1:0]          proc_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy
);

    localparam int IDX_W = (PROC_CNT > 1) ? $clog2(PROC_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROC_CNT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]          state;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_we;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    scan_idx;
    logic                found;
    logic [PROC_CNT-1:0] grant_onehot;

    // Scan upward from the processor after the last grant, wrapping by compare
    // so non-power-of-two counts never visit an out-of-range index.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = last_grant;
        for (int k = 0; k < PROC_CNT; k++) begin
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            if (!found && proc_req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST_IDX;
            grant_idx  <= '0;
            grant_we   <= 1'b0;
            proc_ack   <= '0;
            proc_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            proc_ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx  <= winner;
                        last_grant <= winner;
                        grant_we   <= proc_we[winner];
                        mem_addr   <= proc_addr[winner*ADDR_W +: ADDR_W];
                        mem_wdata  <= proc_wdata[winner*DATA_W +: DATA_W];
                        mem_we     <= proc_we[winner];
                        mem_re     <= !proc_we[winner];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (grant_we) begin
                        proc_ack <= grant_onehot;
                        state    <= ACK;
                    end else begin
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    proc_rdata <= mem_rdata;
                    proc_ack   <= grant_onehot;
                    state      <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_memory_arbiter
// Purpose  : Directed bench for shared_memory_arbiter at PROC_CNT = 4, 3, 1.
// Revision : 1.0  initial release
// ============================================================================
module tb_shared_memory_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_cyc;

    // PROC_CNT = 4 instance
    logic [3:0]  req4 = '0, we4 = '0, ack4;
    logic [31:0] addr4 = '0, wdata4 = '0;
    logic [7:0]  rdata4, maddr4, mwdata4, mrdata4;
    logic        mwe4, mre4, busy4;

    // PROC_CNT = 3 instance
    logic [2:0]  req3 = '0, we3 = '0, ack3;
    logic [23:0] addr3 = '0, wdata3 = '0;
    logic [7:0]  rdata3, maddr3, mwdata3, mrdata3;
    logic        mwe3, mre3, busy3;

    // PROC_CNT = 1 instance
    logic [0:0]  req1 = '0, we1 = '0, ack1;
    logic [7:0]  addr1 = '0, wdata1 = '0;
    logic [7:0]  rdata1, maddr1, mwdata1, mrdata1;
    logic        mwe1, mre1, busy1;

    shared_memory_arbiter #(.PROC_CNT(4), .ADDR_W(8), .DATA_W(8)) dut4 (
        .clock(clock), .reset(reset), .proc_req(req4), .proc_we(we4),
        .proc_addr(addr4), .proc_wdata(wdata4), .proc_ack(ack4),
        .proc_rdata(rdata4), .mem_addr(maddr4), .mem_wdata(mwdata4),
        .mem_we(mwe4), .mem_re(mre4), .mem_rdata(mrdata4), .busy(busy4)
    );

    shared_memory_arbiter #(.PROC_CNT(3), .ADDR_W(8), .DATA_W(8)) dut3 (
        .clock(clock), .reset(reset), .proc_req(req3), .proc_we(we3),
        .proc_addr(addr3), .proc_wdata(wdata3), .proc_ack(ack3),
        .proc_rdata(rdata3), .mem_addr(maddr3), .mem_wdata(mwdata3),
        .mem_we(mwe3), .mem_re(mre3), .mem_rdata(mrdata3), .busy(busy3)
    );

    shared_memory_arbiter #(.PROC_CNT(1), .ADDR_W(8), .DATA_W(8)) dut1 (
        .clock(clock), .reset(reset), .proc_req(req1), .proc_we(we1),
        .proc_addr(addr1), .proc_wdata(wdata1), .proc_ack(ack1),
        .proc_rdata(rdata1), .mem_addr(maddr1), .mem_wdata(mwdata1),
        .mem_we(mwe1), .mem_re(mre1), .mem_rdata(mrdata1), .busy(busy1)
    );

    // Memories with registered read; unwritten locations read as addr ^ 8'h4A.
    bit [7:0] m4 [256];
    bit       v4 [256];
    bit [7:0] m3 [256];
    bit       v3 [256];
    bit [7:0] m1 [256];
    bit       v1 [256];

    always @(posedge clock) begin
        if (mwe4) begin m4[maddr4] <= mwdata4; v4[maddr4] <= 1'b1; end
        if (mre4) mrdata4 <= v4[maddr4] ? m4[maddr4] : (maddr4 ^ 8'h4A);
        if (mwe3) begin m3[maddr3] <= mwdata3; v3[maddr3] <= 1'b1; end
        if (mre3) mrdata3 <= v3[maddr3] ? m3[maddr3] : (maddr3 ^ 8'h4A);
        if (mwe1) begin m1[maddr1] <= mwdata1; v1[maddr1] <= 1'b1; end
        if (mre1) mrdata1 <= v1[maddr1] ? m1[maddr1] : (maddr1 ^ 8'h4A);
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ack_of(input int which);
        case (which)
            0:       return ack4;
            1:       return {1'b0, ack3};
            default: return {3'b000, ack1};
        endcase
    endfunction

    // Poll a bounded number of cycles for any ack, then compare it.
    task automatic wait_ack(input int which, input logic [3:0] exp, input string tag);
        int n = 0;
        while (ack_of(which) == 4'b0000 && n < 12) begin
            tick();
            n++;
        end
        chk(tag, {28'd0, ack_of(which)}, {28'd0, exp});
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy4",   busy4,   0);
        chk("rst_ack4",    ack4,    0);
        chk("rst_rdata4",  rdata4,  0);
        chk("rst_mwe4",    mwe4,    0);
        chk("rst_mre4",    mre4,    0);
        chk("rst_maddr4",  maddr4,  0);
        chk("rst_mwdata4", mwdata4, 0);
        chk("rst_busy3",   busy3,   0);
        chk("rst_busy1",   busy1,   0);
        reset = 1'b0;
        tick();

        // Proc 0 reads 0x10 (holds 0x5A): four-cycle read latency.
        addr4[0 +: 8] = 8'h10;
        we4[0]  = 1'b0;
        req4[0] = 1'b1;
        tick();
        chk("rd_mre_t1",   mre4,   1);
        chk("rd_mwe_t1",   mwe4,   0);
        chk("rd_addr_t1",  maddr4, 8'h10);
        chk("rd_busy_t1",  busy4,  1);
        tick();
        chk("rd_mre_t2",   mre4,   0);
        chk("rd_ack_t2",   ack4,   0);
        tick();
        chk("rd_ack_t3",   ack4,   4'b0001);
        chk("rd_data_t3",  rdata4, 8'h5A);
        tick();
        chk("rd_ack_t4",   ack4,   0);
        chk("rd_busy_t4",  busy4,  0);
        req4[0] = 1'b0;
        tick();

        // Proc 2 writes 0x3C to 0x20: three-cycle write latency.
        addr4[16 +: 8]  = 8'h20;
        wdata4[16 +: 8] = 8'h3C;
        we4[2]  = 1'b1;
        req4[2] = 1'b1;
        tick();
        chk("wr_mwe_t1",   mwe4,    1);
        chk("wr_mre_t1",   mre4,    0);
        chk("wr_addr_t1",  maddr4,  8'h20);
        chk("wr_data_t1",  mwdata4, 8'h3C);
        tick();
        chk("wr_ack_t2",   ack4,    4'b0100);
        chk("wr_mwe_t2",   mwe4,    0);
        chk("wr_rdata_kept", rdata4, 8'h5A);
        tick();
        req4[2] = 1'b0;
        tick();
        we4[2]  = 1'b0;
        req4[2] = 1'b1;
        wait_ack(0, 4'b0100, "rdback_ack");
        chk("rdback_data", rdata4, 8'h3C);
        tick();
        req4[2] = 1'b0;
        tick();

        // All four read continuously from reset: strict rotation, 4 cycles apart.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            addr4[i*8 +: 8] = 8'(8'h40 + i);
            we4[i] = 1'b0;
        end
        req4 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_ack(0, 4'(1 << (k % 4)), "rr_ack");
            if (k > 0) chk("rr_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            chk("rr_rdata", rdata4, (8'h40 + (k % 4)) ^ 8'h4A);
            tick();
            req4[k % 4] = 1'b0;
            tick();
            req4[k % 4] = 1'b1;
        end
        req4 = 4'b0000;
        repeat (6) tick();

        // Reset during WAIT of a proc 0 read drops the access with no ack.
        req4[0] = 1'b1;
        tick();
        tick();
        chk("rw_busy_wait", busy4, 1);
        reset = 1'b1;
        req4  = 4'b0000;
        #1;
        chk("rw_busy_async",  busy4,  0);
        chk("rw_ack_async",   ack4,   0);
        chk("rw_rdata_async", rdata4, 0);
        tick();
        chk("rw_ack_held", ack4, 0);
        reset = 1'b0;
        tick();
        chk("rw_ack_after", ack4, 0);
        req4 = 4'b0011;
        wait_ack(0, 4'b0001, "rw_first_grant");
        tick();
        req4 = 4'b0000;
        repeat (6) tick();

        // PROC_CNT = 3, last_grant = 2: wrap 2 -> 0, then proc 2.
        addr3[0 +: 8]  = 8'h30;
        addr3[16 +: 8] = 8'h32;
        req3 = 3'b101;
        wait_ack(1, 4'b0001, "p3_wrap_ack");
        chk("p3_wrap_data", rdata3, 8'h7A);
        tick();
        req3[0] = 1'b0;
        wait_ack(1, 4'b0100, "p3_next_ack");
        chk("p3_next_data", rdata3, 8'h78);
        tick();
        req3 = 3'b000;
        tick();

        // PROC_CNT = 1: write then read back with one low request cycle.
        addr1  = 8'h05;
        wdata1 = 8'h77;
        we1    = 1'b1;
        req1   = 1'b1;
        wait_ack(2, 4'b0001, "p1_wr_ack");
        tick();
        req1 = 1'b0;
        tick();
        we1  = 1'b0;
        req1 = 1'b1;
        wait_ack(2, 4'b0001, "p1_rd_ack");
        chk("p1_rd_data", rdata1, 8'h77);
        tick();
        req1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_memory_arbiter.md
# shared_memory_arbiter

Round-robin arbiter that shares one single-port data memory between the PROC_CNT processors of the cluster. It sits beside the dispatcher: each processor presents at most one outstanding read or write, and the arbiter serialises them onto the memory port, returning read data and a one-cycle acknowledge to the requester. Fairness is strict rotation, so no processor can be starved by its neighbours.

## Interface
- PROC_CNT, 4, number of processors (≥1, any value, not only powers of two)
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- proc_req  input  PROC_CNT  bit i = processor i requests access (level)
- proc_we  input  PROC_CNT  bit i = 1 write, 0 read; valid while proc_req[i]
- proc_addr  input  PROC_CNT*ADDR_W  slice i = [i*ADDR_W +: ADDR_W]
- proc_wdata  input  PROC_CNT*DATA_W  slice i, used only for writes
- proc_ack  output  PROC_CNT  one-hot, one-cycle pulse: access of processor i complete
- proc_rdata  output  DATA_W  read data, shared by all; valid when the matching proc_ack bit is high
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_we  output  1  memory write strobe
- mem_re  output  1  memory read strobe
- mem_rdata  input  DATA_W  memory read data, registered inside memory: valid the cycle after mem_re
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any proc_req bit set, select the winner, latch its index, we, addr, wdata into internal registers; go to ISSUE. Else stay.
- Winner: first set bit scanning upward from (last_grant+1) mod PROC_CNT, wrapping at PROC_CNT-1 → 0. Wrap uses an explicit compare against PROC_CNT-1, never natural counter overflow. last_grant updates to the winner when it is latched.
- ISSUE: drive mem_addr/mem_wdata from the latched values; mem_we=1 for a write, else mem_re=1, for exactly this cycle. Write → ACK; read → WAIT.
- WAIT: capture mem_rdata into proc_rdata; go to ACK.
- ACK: proc_ack[winner]=1 for this cycle only; go to IDLE.
- Requester rule: hold req/we/addr/wdata stable from assertion until ack is seen; deassert req at the edge ending the ack cycle, so req is low in the following IDLE cycle. Re-request is allowed after at least one cycle low.
- Inputs of a processor are ignored while another processor's access is in flight; a request asserted mid-transaction waits for IDLE.
- Index register width is max(1, $clog2(PROC_CNT)); PROC_CNT=1 always grants processor 0.
- proc_rdata holds its last value until the next read's WAIT; write accesses do not alter it.

## Timing
- Reset values: state=IDLE, last_grant=PROC_CNT-1 (processor 0 wins first), proc_ack=0, proc_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0.
- Reset mid-transaction: all outputs clear asynchronously; the in-flight access is dropped with no ack; a write in ISSUE may be cut short and is not guaranteed complete.
- Read latency: req seen in IDLE cycle T → mem_re at T+1 → rdata captured at T+2 → proc_ack at T+3. Four cycles per read.
- Write latency: IDLE T → mem_we at T+1 → proc_ack at T+2. Three cycles per write.
- mem_we and mem_re never high together; strobes high only in ISSUE.
- mem_addr/mem_wdata are registered and may hold stale values outside ISSUE.
- Simultaneous requests: exactly one granted per transaction; the others stay pending and are served in rotation order.

## Test plan
- After reset, proc 0 reads addr 0x10 (memory holds 0x5A) → mem_re at T+1 with mem_addr=0x10; proc_ack=0001 and proc_rdata=0x5A at T+3.
- Proc 2 writes 0x3C to 0x20 → mem_we=1, mem_addr=0x20, mem_wdata=0x3C at T+1 only; proc_ack=0100 at T+2; a following read of 0x20 returns 0x3C.
- All four procs request reads continuously from reset → grants in order 0,1,2,3,0,… with each ack 4 cycles apart; no processor is skipped.
- PROC_CNT=3, last_grant=2, procs 0 and 2 requesting → proc 0 is granted (wrap 2→0), then proc 2.
- Reset asserted during WAIT of a read → proc_ack stays 0 and busy=0 immediately; the first request after reset is arbitrated from proc 0.
- PROC_CNT=1, back-to-back write then read with one low req cycle between → two acks, write data read back correctly.
